// File: rtl/cd_key_ctrl.sv
// rtl/cd_key_ctrl.sv - front-panel key conditioning and countdown control FSM
// Two active-low buttons are synchronised, debounced and turned into run/load/done control.
module cd_key_ctrl #(
    parameter int DEB_CYC  = 160,
    parameter int LONG_CYC = 8000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key_n,
    input  logic       zero,
    output logic       run,
    output logic       load,
    output logic       done
);

    localparam int DW = $clog2(DEB_CYC);
    localparam int HW = $clog2(LONG_CYC + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [DW-1:0] cnt [2];
    logic [1:0]    flip;
    logic [HW-1:0] hold;
    logic          k0_evt;
    logic          k1_short;
    logic          k1_long;
    logic          press1;
    logic          release1;
    state_t        state;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            flip[i] = (sync2[i] != deb[i]) && (cnt[i] == DEB_LAST);
        end
    end

    assign press1   = flip[1] & deb[1];
    assign release1 = flip[1] & ~deb[1];
    // Fires during the cycle in which the hold counter steps onto LONG_CYC;
    // saturation guarantees it cannot recur within one press.
    assign k1_long  = ~deb[1] && (hold == HOLD_PRE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= 2'b11;
            sync2    <= 2'b11;
            deb      <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
            hold     <= '0;
            k0_evt   <= 1'b0;
            k1_short <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if ((sync2[i] == deb[i]) || flip[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DW'(1);
                end
                if (flip[i]) begin
                    deb[i] <= sync2[i];
                end
            end
            k0_evt <= flip[0] & deb[0];
            // The release cycle itself still counts as held, so a release that
            // coincides with k1_long is a long press, not a short one.
            k1_short <= release1 && (hold < HOLD_PRE);
            if (press1) begin
                hold <= '0;
            end else if (!deb[1] && (hold != HOLD_MAX)) begin
                hold <= hold + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            run   <= 1'b0;
            load  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state_t nxt;
            nxt = state;
            if (k1_short) begin
                nxt = ST_IDLE;
            end else if (k1_long) begin
                nxt = ST_RUN;
            end else begin
                case (state)
                    ST_IDLE:  if (k0_evt) nxt = zero ? ST_DONE : ST_RUN;
                    ST_RUN:   if (zero) nxt = ST_DONE;
                              else if (k0_evt) nxt = ST_PAUSE;
                    ST_PAUSE: if (k0_evt) nxt = zero ? ST_DONE : ST_RUN;
                    default:  nxt = state;
                endcase
            end
            state <= nxt;
            run   <= (nxt == ST_RUN);
            done  <= (nxt == ST_DONE);
            load  <= k1_short | k1_long;
        end
    end

endmodule
